// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between the fetch (IF) and memory (MEM) stages.
// Each grant runs a multi-cycle transaction: address phase, read wait states, one-cycle completion ack.
module mem_port_arbiter #(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 16,
  parameter int WAIT_CYC = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic              mem_ack,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              stall_if,
  output logic              stall_mem,
  output logic              busy
);

  // Handshake: a requester raises req (level) with stable attributes and holds it until its
  // one-cycle ack; attributes are captured at grant, and a grant always runs to its ack.

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_WAIT   = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYC);

  state_t     state, state_nx;
  logic [3:0] count, count_nx;
  logic       owner_mem;
  logic       last_mem;
  logic       we_q;
  logic       grant_vld;
  logic       grant_mem;

  always_comb begin
    grant_vld = if_req | mem_req;
    grant_mem = mem_req;
    if (if_req && mem_req) grant_mem = ~last_mem;
  end

  always_comb begin
    state_nx = state;
    count_nx = count;
    case (state)
      S_IDLE: begin
        if (grant_vld) state_nx = S_ACCESS;
      end
      S_ACCESS: begin
        if (we_q) begin
          state_nx = S_DONE;
        end else begin
          count_nx = WAIT_INIT;
          state_nx = S_WAIT;
        end
      end
      S_WAIT: begin
        count_nx = count - 4'd1;
        if (count == 4'd1) state_nx = S_DONE;
      end
      S_DONE: begin
        state_nx = S_IDLE;
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      count     <= 4'd0;
      owner_mem <= 1'b0;
      last_mem  <= 1'b0;
      we_q      <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      if_rdata  <= '0;
      mem_rdata <= '0;
    end else begin
      state <= state_nx;
      count <= count_nx;
      if (state == S_IDLE && grant_vld) begin
        owner_mem <= grant_mem;
        last_mem  <= grant_mem;
        we_q      <= grant_mem & mem_we;
        ram_addr  <= grant_mem ? mem_addr : if_addr;
        if (grant_mem) ram_wdata <= mem_wdata;
      end
      // Read data is valid on the last wait-state cycle; steer it to the owning port.
      if (state == S_WAIT && count == 4'd1) begin
        if (owner_mem) mem_rdata <= ram_rdata;
        else           if_rdata  <= ram_rdata;
      end
    end
  end

  assign ram_en    = (state == S_ACCESS);
  assign ram_we    = ram_en & we_q;
  assign if_ack    = (state == S_DONE) & ~owner_mem;
  assign mem_ack   = (state == S_DONE) & owner_mem;
  assign busy      = (state != S_IDLE);
  assign stall_if  = if_req & ~if_ack;
  assign stall_mem = mem_req & ~mem_ack;

endmodule
